chunked_serial_adder: RTL and testbench



---
 rtl/chunked_serial_adder_pkg.sv | 20 ++
 rtl/chunked_serial_adder_chunk_adder.sv | 24 ++
 rtl/chunked_serial_adder.sv | 133 +++++++++++++
 tb/tb_chunked_serial_adder.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/chunked_serial_adder_pkg.sv
// Shared types and sizing helpers for the chunked serial adder.
package chunked_serial_adder_pkg;

    typedef enum logic {
        IDLE,
        RUN
    } state_e;

    function automatic int unsigned num_steps(input int unsigned width, input int unsigned chunk);
        return width / chunk;
    endfunction

    // Step counter must hold at least one bit even when a single step suffices.
    function automatic int unsigned cnt_width(input int unsigned width, input int unsigned chunk);
        int unsigned n;
        n = num_steps(width, chunk);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/chunked_serial_adder_chunk_adder.sv
// Combinational CHUNK-bit ripple-carry slice reused every step of the serial adder.
module chunk_adder #(
    parameter int unsigned CHUNK = 1
) (
    input  logic [CHUNK-1:0] x,
    input  logic [CHUNK-1:0] y,
    input  logic             ci,
    output logic [CHUNK-1:0] s,
    output logic             co
);

    logic c;

    always_comb begin
        s = '0;
        c = ci;
        for (int unsigned i = 0; i < CHUNK; i++) begin
            s[i] = x[i] ^ y[i] ^ c;
            c    = (x[i] & y[i]) | (c & (x[i] ^ y[i]));
        end
        co = c;
    end

endmodule

// File: rtl/chunked_serial_adder.sv
// Multi-cycle adder processing CHUNK bits per clock through one registered carry.
// Optional subtract mode enabled by defining CHUNKED_SERIAL_ADDER_SUB_EN.
module chunked_serial_adder
    import chunked_serial_adder_pkg::*;
#(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned CHUNK = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             Cin,
`ifdef CHUNKED_SERIAL_ADDER_SUB_EN
    input  logic             sub,
`endif
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             Cout
);

    generate
        if ((WIDTH < 1) || (CHUNK < 1) || ((WIDTH % CHUNK) != 0)) begin : g_bad_cfg
            $error("chunked_serial_adder: CHUNK must be >= 1 and divide WIDTH");
        end
    endgenerate

    localparam int unsigned N  = num_steps(WIDTH, CHUNK);
    localparam int unsigned CW = cnt_width(WIDTH, CHUNK);
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             carry_q, carry_d;
    logic             cout_q, cout_d;
    logic             done_q, done_d;

    logic [WIDTH-1:0] b_cap;
    logic             cin_cap;
    logic [CHUNK-1:0] slice_s;
    logic             slice_co;

    // Subtraction is a + ~b + ~Cin, so Cin behaves as a borrow-in.
`ifdef CHUNKED_SERIAL_ADDER_SUB_EN
    assign b_cap   = sub ? ~b : b;
    assign cin_cap = sub ? ~Cin : Cin;
`else
    assign b_cap   = b;
    assign cin_cap = Cin;
`endif

    chunk_adder #(.CHUNK(CHUNK)) u_chunk (
        .x  (a_q[CHUNK-1:0]),
        .y  (b_q[CHUNK-1:0]),
        .ci (carry_q),
        .s  (slice_s),
        .co (slice_co)
    );

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        acc_d   = acc_q;
        sum_d   = sum_q;
        cnt_d   = cnt_q;
        carry_d = carry_q;
        cout_d  = cout_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    a_d     = a;
                    b_d     = b_cap;
                    carry_d = cin_cap;
                    cnt_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                // Result chunks enter at the top so the first (LSB) chunk lands at bit 0 after N steps.
                acc_d   = (acc_q >> CHUNK) | (WIDTH'(slice_s) << (WIDTH - CHUNK));
                a_d     = a_q >> CHUNK;
                b_d     = b_q >> CHUNK;
                carry_d = slice_co;
                cnt_d   = cnt_q + CW'(1);
                if (cnt_q == LAST) begin
                    sum_d   = acc_d;
                    cout_d  = slice_co;
                    done_d  = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            acc_q   <= '0;
            sum_q   <= '0;
            cnt_q   <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            acc_q   <= acc_d;
            sum_q   <= sum_d;
            cnt_q   <= cnt_d;
            carry_q <= carry_d;
            cout_q  <= cout_d;
            done_q  <= done_d;
        end
    end

    assign busy = (state_q == RUN);
    assign done = done_q;
    assign sum  = sum_q;
    assign Cout = cout_q;

endmodule

// File: tb/tb_chunked_serial_adder.sv
// Self-checking bench: three WIDTH=8 instances with CHUNK=1, 4 and 8.
module tb_chunked_serial_adder;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] a = '0, b = '0;
    logic       cin = 1'b0;
    logic       start1 = 1'b0, start4 = 1'b0, start8 = 1'b0;
`ifdef CHUNKED_SERIAL_ADDER_SUB_EN
    logic       sub = 1'b0;
`endif

    logic       busy1, done1, cout1;
    logic       busy4, done4, cout4;
    logic       busy8, done8, cout8;
    logic [7:0] sum1, sum4, sum8;

    int         sel = 0;
    logic       busy_m, done_m, cout_m;
    logic [7:0] sum_m;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    chunked_serial_adder #(.WIDTH(8), .CHUNK(1)) u_c1 (
        .clk(clk), .rst(rst), .start(start1), .a(a), .b(b), .Cin(cin),
`ifdef CHUNKED_SERIAL_ADDER_SUB_EN
        .sub(sub),
`endif
        .busy(busy1), .done(done1), .sum(sum1), .Cout(cout1));

    chunked_serial_adder #(.WIDTH(8), .CHUNK(4)) u_c4 (
        .clk(clk), .rst(rst), .start(start4), .a(a), .b(b), .Cin(cin),
`ifdef CHUNKED_SERIAL_ADDER_SUB_EN
        .sub(sub),
`endif
        .busy(busy4), .done(done4), .sum(sum4), .Cout(cout4));

    chunked_serial_adder #(.WIDTH(8), .CHUNK(8)) u_c8 (
        .clk(clk), .rst(rst), .start(start8), .a(a), .b(b), .Cin(cin),
`ifdef CHUNKED_SERIAL_ADDER_SUB_EN
        .sub(sub),
`endif
        .busy(busy8), .done(done8), .sum(sum8), .Cout(cout8));

    always_comb begin
        busy_m = busy1; done_m = done1; sum_m = sum1; cout_m = cout1;
        case (sel)
            1: begin busy_m = busy4; done_m = done4; sum_m = sum4; cout_m = cout4; end
            2: begin busy_m = busy8; done_m = done8; sum_m = sum8; cout_m = cout8; end
            default: ;
        endcase
    end

    function automatic int latency_of(input int s);
        return (s == 0) ? 8 : (s == 1) ? 2 : 1;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Called at a negedge: presents operands with start, steps over the start edge.
    task automatic launch(input int s, input logic [7:0] av, input logic [7:0] bv, input logic cv);
        sel = s;
        a = av; b = bv; cin = cv;
        start1 = (s == 0); start4 = (s == 1); start8 = (s == 2);
        @(posedge clk);
        @(negedge clk);
        start1 = 1'b0; start4 = 1'b0; start8 = 1'b0;
    endtask

    // Counts edges until done is seen; busy must stay high meanwhile.
    task automatic wait_done(output int cyc);
        bit busy_ok = 1'b1;
        bit seen = 1'b0;
        cyc = 0;
        while (!seen && cyc < 40) begin
            @(posedge clk);
            cyc++;
            @(negedge clk);
            if (done_m) seen = 1'b1;
            else if (!busy_m) busy_ok = 1'b0;
        end
        chk("done_seen", 32'(seen), 32'd1);
        chk("busy_during_run", 32'(busy_ok), 32'd1);
        chk("busy_low_at_done", 32'(busy_m), 32'd0);
    endtask

    typedef struct {
        int         s;
        logic [7:0] av;
        logic [7:0] bv;
        logic       cv;
        logic [8:0] exp;
    } vec_t;

    vec_t vecs[6];

    initial begin
        int cyc;
        logic [8:0] model;
        int s;
        logic [7:0] ra, rb;
        logic rc;

        vecs[0] = '{0, 8'h00, 8'h00, 1'b0, 9'h000};
        vecs[1] = '{0, 8'hFF, 8'h01, 1'b0, 9'h100};
        vecs[2] = '{0, 8'hA5, 8'h5A, 1'b1, 9'h100};
        vecs[3] = '{1, 8'h7F, 8'h01, 1'b0, 9'h080};
        vecs[4] = '{2, 8'h80, 8'h80, 1'b1, 9'h101};
        vecs[5] = '{1, 8'hFF, 8'hFF, 1'b1, 9'h1FF};

        repeat (2) @(negedge clk);
        rst = 1'b0;
        chk("reset_busy", {29'd0, busy1, busy4, busy8}, 32'd0);
        chk("reset_done", {29'd0, done1, done4, done8}, 32'd0);
        chk("reset_sum", {8'd0, sum1, sum4, sum8}, 32'd0);
        chk("reset_cout", {29'd0, cout1, cout4, cout8}, 32'd0);

        for (int i = 0; i < 6; i++) begin
            launch(vecs[i].s, vecs[i].av, vecs[i].bv, vecs[i].cv);
            chk("busy_after_start", 32'(busy_m), 32'd1);
            wait_done(cyc);
            chk("vec_latency", 32'(cyc), 32'(latency_of(vecs[i].s)));
            chk("vec_result", {23'd0, cout_m, sum_m}, {23'd0, vecs[i].exp});
            @(negedge clk);
            chk("done_one_cycle", 32'(done_m), 32'd0);
            chk("result_held", {23'd0, cout_m, sum_m}, {23'd0, vecs[i].exp});
        end

        // Start while busy is ignored; start in the done cycle is accepted.
        launch(0, 8'hA5, 8'h5A, 1'b1);
        @(posedge clk); @(negedge clk);
        @(posedge clk); @(negedge clk);
        a = 8'h11; b = 8'h00; cin = 1'b0; start1 = 1'b1;
        @(posedge clk); @(negedge clk);
        start1 = 1'b0;
        chk("ignored_start_busy", 32'(busy1), 32'd1);
        wait_done(cyc);
        chk("ignored_start_latency", 32'(cyc + 3), 32'd8);
        chk("ignored_start_result", {23'd0, cout1, sum1}, 32'h100);
        launch(0, 8'h12, 8'h34, 1'b0);
        chk("done_cycle_start_busy", 32'(busy1), 32'd1);
        chk("done_cycle_start_done_drop", 32'(done1), 32'd0);
        wait_done(cyc);
        chk("done_cycle_latency", 32'(cyc), 32'd8);
        chk("done_cycle_result", {23'd0, cout1, sum1}, 32'h046);

        // Reset mid-operation abandons the add and clears the result.
        launch(0, 8'h3C, 8'h0F, 1'b0);
        repeat (3) begin @(posedge clk); @(negedge clk); end
        rst = 1'b1;
        @(posedge clk); @(negedge clk);
        rst = 1'b0;
        chk("midreset_busy", 32'(busy1), 32'd0);
        chk("midreset_done", 32'(done1), 32'd0);
        chk("midreset_result", {23'd0, cout1, sum1}, 32'd0);
        begin
            bit stray = 1'b0;
            repeat (10) begin
                @(posedge clk); @(negedge clk);
                if (done1) stray = 1'b1;
            end
            chk("midreset_no_done", 32'(stray), 32'd0);
        end
        launch(0, 8'h3C, 8'h0F, 1'b0);
        wait_done(cyc);
        chk("post_reset_result", {23'd0, cout1, sum1}, 32'h04B);

        // Randomized operations against plain arithmetic.
        for (int i = 0; i < 30; i++) begin
            s  = int'($urandom_range(0, 2));
            ra = 8'($urandom);
            rb = 8'($urandom);
            rc = 1'($urandom);
            model = {1'b0, ra} + {1'b0, rb} + {8'd0, rc};
            launch(s, ra, rb, rc);
            wait_done(cyc);
            chk("rand_latency", 32'(cyc), 32'(latency_of(s)));
            chk("rand_result", {23'd0, cout_m, sum_m}, {23'd0, model});
        end

`ifdef CHUNKED_SERIAL_ADDER_SUB_EN
        sub = 1'b1;
        launch(0, 8'h05, 8'h07, 1'b0);
        wait_done(cyc);
        chk("sub_borrow", {23'd0, cout1, sum1}, 32'h0FE);
        launch(0, 8'h07, 8'h05, 1'b1);
        wait_done(cyc);
        chk("sub_no_borrow", {23'd0, cout1, sum1}, 32'h101);
        sub = 1'b0;
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
